// File: rtl/ps2_scancode_rx_if.sv
// rtl/ps2_scancode_rx_if.sv - PS/2 pin and key-event signal bundle
interface ps2_scancode_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver: deglitch, deserialise, fold E0/F0 into key events
module ps2_scancode_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12000
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    ps2_scancode_rx_if.slave   ps2
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic [7:0]    filt_cnt_q, filt_cnt_d;
    logic          clk_f_q, clk_f_d;
    logic          fall_q;
    logic          dat_fall_q;

    state_t        state_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [2:0]    bitcnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          ext_q, brk_q;
    logic [2:0]    skip_q;
    logic [10:0]   key_q;
    logic          err_q;

    logic          frame_ok;
    logic          is_reply;

    // Filter counts consecutive samples that disagree with the filtered level.
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        clk_f_d    = clk_f_q;
        if (clk_s2_q == clk_f_q) begin
            filt_cnt_d = 8'd0;
        end else if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
            clk_f_d    = clk_s2_q;
            filt_cnt_d = 8'd0;
        end else begin
            filt_cnt_d = filt_cnt_q + 8'd1;
        end
    end

    // Sync and filter state resets high so an idle line gives no edge after reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_cnt_q <= 8'd0;
            clk_f_q    <= 1'b1;
            fall_q     <= 1'b0;
            dat_fall_q <= 1'b1;
        end else begin
            clk_s1_q   <= ps2.ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2.ps2_data;
            dat_s2_q   <= dat_s1_q;
            filt_cnt_q <= filt_cnt_d;
            clk_f_q    <= clk_f_d;
            fall_q     <= clk_f_q & ~clk_f_d;
            dat_fall_q <= dat_s2_q;
        end
    end

    assign frame_ok = dat_fall_q & (^{shift_q, par_q});
    assign is_reply = (shift_q == 8'hAA) || (shift_q == 8'hFA) || (shift_q == 8'hEE) ||
                      (shift_q == 8'hFE) || (shift_q == 8'h00) || (shift_q == 8'hFF);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            bitcnt_q <= 3'd0;
            to_cnt_q <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            skip_q   <= 3'd0;
            key_q    <= 11'h000;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;

            // Timeout only acts without a fall, so a coincident fall wins.
            if (fall_q) begin
                to_cnt_q <= '0;
            end else if (state_q != S_IDLE) begin
                if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_q  <= S_IDLE;
                    to_cnt_q <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end

            if (fall_q) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_fall_q) begin
                            shift_q  <= 8'h00;
                            bitcnt_q <= 3'd0;
                            state_q  <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        shift_q  <= {dat_fall_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_q   <= dat_fall_q;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (!frame_ok) begin
                            err_q <= 1'b1;
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end else if (skip_q != 3'd0) begin
                            skip_q <= skip_q - 3'd1;
                        end else if (shift_q == 8'hE1) begin
                            skip_q <= 3'd7;
                        end else if (shift_q == 8'hE0) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_q <= 1'b1;
                        end else if (!(is_reply && !ext_q && !brk_q)) begin
                            key_q <= {~key_q[10], ~brk_q, ext_q, shift_q};
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ps2.ps2_key   = key_q;
    assign ps2.frame_err = err_q;
    assign ps2.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - self-checking bench for ps2_scancode_rx
module tb_ps2_scancode_rx;
    localparam int FILT = 8;
    localparam int TMO  = 12000;
    localparam int HALF = 40;

    typedef struct {
        logic [7:0]  data;
        logic        bad_par;
        logic        bad_stop;
        int          exp_err;
        logic        exp_evt;
        logic [10:0] exp_key;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   err_seen = 0;
    logic mid_busy = 1'b0;
    logic [10:0] prev_key = 11'h000;
    logic [10:0] exp_q[$];
    vec_t tbl[$];

    ps2_scancode_rx_if bus ();

    ps2_scancode_rx #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ps2     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every ps2_key change must match the oldest pushed expectation.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_key = bus.ps2_key;
        end else begin
            if (bus.ps2_key !== prev_key) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_key_update actual=%0h required=%0h", bus.ps2_key, prev_key);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    if (bus.ps2_key !== e) begin
                        failures++;
                        $display("FAIL key_event actual=%0h required=%0h", bus.ps2_key, e);
                    end
                end
                prev_key = bus.ps2_key;
            end
            if (bus.frame_err === 1'b1) err_seen++;
        end
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bp, input logic bs);
        logic par;
        par = ~(^d) ^ bp;
        return {~bs, par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = f[i];
            repeat (HALF) @(posedge clk_sys);
            #1 bus.ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk_sys);
            #1;
            if (i == 6) mid_busy = bus.busy;
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic settle();
        repeat (30) @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    initial begin
        int   e0;
        logic busy_any;

        tbl.push_back('{8'h29, 1'b0, 1'b0, 0, 1'b1, 11'h629});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'h29, 1'b0, 1'b0, 0, 1'b1, 11'h029});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'h75, 1'b0, 1'b0, 0, 1'b1, 11'h775});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'h75, 1'b0, 1'b0, 0, 1'b1, 11'h175});
        tbl.push_back('{8'h29, 1'b1, 1'b0, 1, 1'b0, 11'h000});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'h29, 1'b0, 1'b1, 1, 1'b0, 11'h000});
        tbl.push_back('{8'h29, 1'b0, 1'b0, 0, 1'b1, 11'h629});
        tbl.push_back('{8'hE1, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'h14, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'h77, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'hE1, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'h14, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'h77, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'h16, 1'b0, 1'b0, 0, 1'b1, 11'h216});
        tbl.push_back('{8'hAA, 1'b0, 1'b0, 0, 1'b0, 11'h000});
        tbl.push_back('{8'hFA, 1'b0, 1'b0, 0, 1'b0, 11'h000});

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk_sys);
        @(negedge clk_sys);
        check("reset_key", 32'(bus.ps2_key), 32'h000);
        check("reset_err", 32'(bus.frame_err), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            e0 = err_seen;
            if (tbl[i].exp_evt) exp_q.push_back(tbl[i].exp_key);
            send_bits(make_frame(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop), 11);
            settle();
            check($sformatf("vec%0d_pending", i), 32'(exp_q.size()), 32'd0);
            check($sformatf("vec%0d_err_pulses", i), 32'(err_seen - e0), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d_busy_after", i), 32'(bus.busy), 32'h0);
            if (i == 0) check("busy_mid_frame", 32'(mid_busy), 32'h1);
        end

        // Short low glitches with data held low: any leak would look like a start bit.
        e0 = err_seen;
        busy_any = 1'b0;
        bus.ps2_data = 1'b0;
        for (int g = 0; g < 5; g++) begin
            @(posedge clk_sys);
            #1 bus.ps2_clk = 1'b0;
            repeat (4) @(posedge clk_sys);
            #1 bus.ps2_clk = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk_sys);
                if (bus.busy) busy_any = 1'b1;
            end
        end
        bus.ps2_data = 1'b1;
        check("glitch_busy", 32'(busy_any), 32'h0);
        check("glitch_err", 32'(err_seen - e0), 32'd0);

        // Partial frame then silence longer than the timeout.
        e0 = err_seen;
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 5);
        settle();
        check("timeout_busy_before", 32'(bus.busy), 32'h1);
        repeat (TMO + 10) @(posedge clk_sys);
        @(negedge clk_sys);
        check("timeout_busy_after", 32'(bus.busy), 32'h0);
        check("timeout_no_err", 32'(err_seen - e0), 32'd0);
        exp_q.push_back(11'h61C);
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11);
        settle();
        check("after_timeout_pending", 32'(exp_q.size()), 32'd0);
        check("after_timeout_code", 32'(bus.ps2_key[8:0]), 32'h01C);

        // Asynchronous reset in the middle of a frame.
        send_bits(make_frame(8'h16, 1'b0, 1'b0), 6);
        settle();
        check("midreset_busy_before", 32'(bus.busy), 32'h1);
        @(posedge clk_sys);
        #3 reset_n = 1'b0;
        #1;
        check("midreset_key", 32'(bus.ps2_key), 32'h000);
        check("midreset_busy", 32'(bus.busy), 32'h0);
        check("midreset_err", 32'(bus.frame_err), 32'h0);
        repeat (5) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk_sys);
        exp_q.push_back(11'h616);
        send_bits(make_frame(8'h16, 1'b0, 1'b0), 11);
        settle();
        check("post_reset_pending", 32'(exp_q.size()), 32'd0);
        check("post_reset_key", 32'(bus.ps2_key), 32'h616);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
